zjh_vote_ctrl: RTL and testbench

Sequential ballot controller for the three-voter majority voting unit. It opens a timed voting window on a start pulse and latches at most one "yes" vote per voter from raw push-button inputs. The window closes on timeout or when all three voters have voted. It then tallies the votes and holds a registered pass/fail verdict plus vote status for the display and LED stage. It sits between the board keys and the output pins, and it sequences and registers what the combinational voter only evaluates instantaneously.

---
 rtl/zjh_vote_ctrl.sv | 165 ++++++++++++++++
 tb/tb_zjh_vote_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zjh_vote_ctrl.sv
// zjh_vote_ctrl
// Sequential ballot controller for the three-voter majority unit. A start
// pulse opens a voting window of WINDOW clk cycles; each voter's raw "yes"
// key is synchronised and edge-detected, and at most one vote per voter is
// latched. The window closes on timeout or once all three have voted, after
// which the tally and a registered pass/fail verdict are held for display.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   synchronous pulse, opens a ballot (IDLE or RESULT)
//   clear    in   synchronous abort back to IDLE, beats start and keys
//   key_a/b/c in  raw asynchronous active-high voter buttons
//   busy     out  high while the window is open
//   voted    out  latched votes {c,b,a}
//   yes_cnt  out  number of latched votes
//   pass     out  registered verdict (yes_cnt >= 2), valid in RESULT
//   done     out  one-cycle pulse on entry to RESULT
//   remain   out  cycles left in the window, 0 outside VOTING
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no ballot; outputs cleared, key edges ignored
// ST_VOTING | window open; latch first edge per voter, count down remain
// ST_RESULT | ballot closed; tally and verdict held until start/clear

module zjh_vote_ctrl #(
    parameter int WINDOW = 1000,
    localparam int CW = $clog2(WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic          key_a,
    input  logic          key_b,
    input  logic          key_c,
    output logic          busy,
    output logic [2:0]    voted,
    output logic [1:0]    yes_cnt,
    output logic          pass,
    output logic          done,
    output logic [CW-1:0] remain
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTING = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    voted_nxt;
    logic [1:0]    yes_cnt_nxt;
    logic          pass_nxt;
    logic          done_nxt;
    logic [CW-1:0] remain_nxt;

    logic [2:0] key_s1, key_s2, key_s3;
    logic [2:0] key_edge;
    logic [2:0] new_votes;

    // Two-flop synchroniser plus a previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 3'b000;
            key_s2 <= 3'b000;
            key_s3 <= 3'b000;
        end else begin
            key_s1 <= {key_c, key_b, key_a};
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign key_edge  = key_s2 & ~key_s3;
    assign new_votes = key_edge & ~voted;
    assign busy      = (state == ST_VOTING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            voted   <= 3'b000;
            yes_cnt <= 2'd0;
            pass    <= 1'b0;
            done    <= 1'b0;
            remain  <= '0;
        end else begin
            state   <= state_nxt;
            voted   <= voted_nxt;
            yes_cnt <= yes_cnt_nxt;
            pass    <= pass_nxt;
            done    <= done_nxt;
            remain  <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        voted_nxt   = voted;
        yes_cnt_nxt = yes_cnt;
        pass_nxt    = pass;
        done_nxt    = 1'b0;
        remain_nxt  = remain;

        case (state)
            ST_IDLE: begin
                voted_nxt   = 3'b000;
                yes_cnt_nxt = 2'd0;
                pass_nxt    = 1'b0;
                remain_nxt  = '0;
                if (start) begin
                    state_nxt  = ST_VOTING;
                    remain_nxt = CW'(WINDOW - 1);
                end
            end

            ST_VOTING: begin
                voted_nxt   = voted | new_votes;
                yes_cnt_nxt = yes_cnt + 2'(new_votes[0]) + 2'(new_votes[1])
                              + 2'(new_votes[2]);
                // The full-house check uses the registered vote so the
                // third vote is visible for one cycle before RESULT; an edge
                // arriving in the remain==0 cycle still makes the verdict.
                if (remain == '0 || voted == 3'b111) begin
                    state_nxt  = ST_RESULT;
                    done_nxt   = 1'b1;
                    remain_nxt = '0;
                    pass_nxt   = (yes_cnt_nxt >= 2'd2);
                end else begin
                    remain_nxt = remain - 1'b1;
                end
            end

            ST_RESULT: begin
                remain_nxt = '0;
                if (start) begin
                    state_nxt   = ST_VOTING;
                    voted_nxt   = 3'b000;
                    yes_cnt_nxt = 2'd0;
                    pass_nxt    = 1'b0;
                    remain_nxt  = CW'(WINDOW - 1);
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                voted_nxt   = 3'b000;
                yes_cnt_nxt = 2'd0;
                pass_nxt    = 1'b0;
                remain_nxt  = '0;
            end
        endcase

        if (clear) begin
            state_nxt   = ST_IDLE;
            voted_nxt   = 3'b000;
            yes_cnt_nxt = 2'd0;
            pass_nxt    = 1'b0;
            done_nxt    = 1'b0;
            remain_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_zjh_vote_ctrl.sv
// tb_zjh_vote_ctrl
// Directed bench for zjh_vote_ctrl with WINDOW=16. Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point.

module tb_zjh_vote_ctrl;

    localparam int WINDOW = 16;
    localparam int CW     = $clog2(WINDOW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          key_a = 1'b0;
    logic          key_b = 1'b0;
    logic          key_c = 1'b0;
    logic          busy;
    logic [2:0]    voted;
    logic [1:0]    yes_cnt;
    logic          pass;
    logic          done;
    logic [CW-1:0] remain;

    int n_checks = 0;
    int n_fails  = 0;
    int busy_cycles;
    int n_done;

    zjh_vote_ctrl #(.WINDOW(WINDOW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .clear   (clear),
        .key_a   (key_a),
        .key_b   (key_b),
        .key_c   (key_c),
        .busy    (busy),
        .voted   (voted),
        .yes_cnt (yes_cnt),
        .pass    (pass),
        .done    (done),
        .remain  (remain)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) n_done++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        #12;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_remain", 32'(remain), 0);
        rst_n = 1'b1;
        tick();
        check_val("idle_busy", 32'(busy), 0);
        check_val("idle_voted", 32'(voted), 0);
        check_val("idle_done", 32'(done), 0);
        pulse_start();
        check_val("start_busy", 32'(busy), 1);
        check_val("start_remain", 32'(remain), 15);
        key_a = 1'b1;
        tick();
        tick();
        check_val("lat_not_yet", 32'(voted), 0);
        tick();
        check_val("lat_voted", 32'(voted), 32'b001);
        check_val("lat_cnt", 32'(yes_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 0);
        check_val("arst_voted", 32'(voted), 0);
        check_val("arst_cnt", 32'(yes_cnt), 0);
        check_val("arst_remain", 32'(remain), 0);
        key_a = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        check_val("arst_idle", 32'(busy), 0);

        // ---------------- two voters, timeout ----------------
        pulse_start();
        busy_cycles = 0;
        n_done = 0;
        for (int i = 0; i < 64 && busy; i++) begin
            key_a = (i >= 3 && i < 5);
            key_c = (i >= 7 && i < 9);
            busy_cycles++;
            tick();
        end
        key_a = 1'b0;
        key_c = 1'b0;
        check_val("to_busy_cycles", 32'(busy_cycles), 16);
        check_val("to_done", 32'(done), 1);
        check_val("to_voted", 32'(voted), 32'b101);
        check_val("to_cnt", 32'(yes_cnt), 2);
        check_val("to_pass", 32'(pass), 1);
        check_val("to_remain", 32'(remain), 0);
        repeat (4) tick();
        check_val("to_done_once", 32'(n_done), 1);
        check_val("to_pass_hold", 32'(pass), 1);

        // ---------------- early close ----------------
        pulse_start();
        check_val("ec_cleared", 32'(voted), 0);
        key_a = 1'b1;
        tick();
        key_b = 1'b1;
        tick();
        key_c = 1'b1;
        tick();
        check_val("ec_v1", 32'(voted), 32'b001);
        tick();
        check_val("ec_v2", 32'(voted), 32'b011);
        tick();
        check_val("ec_v3", 32'(voted), 32'b111);
        check_val("ec_cnt3", 32'(yes_cnt), 3);
        check_val("ec_busy_still", 32'(busy), 1);
        check_val("ec_remain", 32'(remain), 10);
        check_val("ec_no_done", 32'(done), 0);
        tick();
        check_val("ec_result_busy", 32'(busy), 0);
        check_val("ec_done", 32'(done), 1);
        check_val("ec_pass", 32'(pass), 1);
        check_val("ec_remain0", 32'(remain), 0);
        key_a = 1'b0;
        key_b = 1'b0;
        key_c = 1'b0;
        tick();
        check_val("ec_done_low", 32'(done), 0);

        // ---------------- hold and duplicates ----------------
        pulse_start();
        busy_cycles = 0;
        n_done = 0;
        for (int i = 0; i < 64 && busy; i++) begin
            key_a = (i < 6) ? 1'b1 : ((i % 4) < 2);
            busy_cycles++;
            tick();
        end
        key_a = 1'b0;
        check_val("dup_busy_cycles", 32'(busy_cycles), 16);
        check_val("dup_cnt", 32'(yes_cnt), 1);
        check_val("dup_voted", 32'(voted), 32'b001);
        check_val("dup_pass", 32'(pass), 0);
        check_val("dup_done", 32'(n_done), 1);

        // ---------------- boundary: B edge in remain==0 cycle ----------------
        pulse_start();
        key_a = 1'b1;
        for (int n = 1; n <= 13; n++) tick();
        key_b = 1'b1;
        tick();
        tick();
        check_val("bnd_remain0", 32'(remain), 0);
        check_val("bnd_busy", 32'(busy), 1);
        check_val("bnd_cnt_pre", 32'(yes_cnt), 1);
        tick();
        check_val("bnd_done", 32'(done), 1);
        check_val("bnd_cnt", 32'(yes_cnt), 2);
        check_val("bnd_voted", 32'(voted), 32'b011);
        check_val("bnd_pass", 32'(pass), 1);
        key_a = 1'b0;
        key_b = 1'b0;
        tick();

        // ---------------- clear + start in VOTING ----------------
        pulse_start();
        key_c = 1'b1;
        repeat (3) tick();
        check_val("clr_pre_voted", 32'(voted), 32'b100);
        key_c = 1'b0;
        n_done = 0;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check_val("clr_busy", 32'(busy), 0);
        check_val("clr_voted", 32'(voted), 0);
        check_val("clr_cnt", 32'(yes_cnt), 0);
        check_val("clr_pass", 32'(pass), 0);
        check_val("clr_remain", 32'(remain), 0);
        repeat (20) tick();
        check_val("clr_no_done", 32'(n_done), 0);
        check_val("clr_stay_idle", 32'(busy), 0);

        // ---------------- re-ballot from RESULT ----------------
        pulse_start();
        key_a = 1'b1;
        key_b = 1'b1;
        key_c = 1'b1;
        tick();
        tick();
        check_val("rb_simul_none", 32'(yes_cnt), 0);
        tick();
        check_val("rb_simul_cnt", 32'(yes_cnt), 3);
        tick();
        check_val("rb_done", 32'(done), 1);
        check_val("rb_pass1", 32'(pass), 1);
        key_a = 1'b0;
        key_b = 1'b0;
        key_c = 1'b0;
        tick();
        pulse_start();
        check_val("rb_voted", 32'(voted), 0);
        check_val("rb_cnt", 32'(yes_cnt), 0);
        check_val("rb_busy", 32'(busy), 1);
        check_val("rb_remain", 32'(remain), 15);
        busy_cycles = 0;
        n_done = 0;
        for (int i = 0; i < 64 && busy; i++) begin
            busy_cycles++;
            tick();
        end
        check_val("rb_busy_cycles", 32'(busy_cycles), 16);
        check_val("rb_end_done", 32'(n_done), 1);
        check_val("rb_end_pass", 32'(pass), 0);
        check_val("rb_end_cnt", 32'(yes_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
